// File: rtl/chesslab_pkg.sv
// Shared definitions for the chess-lab game controller: state codes and default feedback hold time.
package chesslab_pkg;

    localparam int unsigned HOLD_CYCLES_DEFAULT = 25_000_000;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        SORTEIA  = 4'd2,
        ESPERA   = 4'd3,
        REGISTRA = 4'd4,
        COMPARA  = 4'd5,
        ACERTO   = 4'd6,
        ERRO     = 4'd7,
        FIM      = 4'd8
    } estadoT;

endpackage

// File: rtl/cl_hold_timer.sv
// Loadable down-counter that keeps a feedback flag busy for HOLD_CYCLES cycles after a load.
module cl_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic busy
);

    localparam int W = $clog2(HOLD_CYCLES + 1);

    logic [W-1:0] countReg;

    // Clear wins over load; counting saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            countReg <= '0;
        end else if (clear) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= W'(HOLD_CYCLES);
        end else if (countReg != '0) begin
            countReg <= countReg - 1'b1;
        end
    end

    assign busy = (countReg != '0);

endmodule

// File: rtl/chesslab_controle.sv
// Control FSM for the chess-lab target game: sequences datapath strobes and holds hit/miss feedback.
module chesslab_controle
    import chesslab_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       temJogada,
    input  logic       acertou,
    input  logic       fimT,
    input  logic       terminar,
    output logic       zeraT,
    output logic       zeraR,
    output logic       zeraP,
    output logic       registraR,
    output logic       proximoAlvo,
    output logic       contaT,
    output logic       contaP,
    output logic       decresceT,
    output logic       fimJogo,
    output logic       mostraAcerto,
    output logic       mostraErro,
    output logic [3:0] db_estado
);

    estadoT stateReg, stateNext;
    logic   temJogadaReg;
    logic   jogadaEdge;
    logic [1:0] timerLoad, timerClear, timerBusy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg     <= INICIAL;
            temJogadaReg <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            temJogadaReg <= temJogada;
        end
    end

    // A held sensor level produces exactly one move.
    assign jogadaEdge = temJogada & ~temJogadaReg;

    always_comb begin
        stateNext = INICIAL;
        case (stateReg)
            INICIAL:  stateNext = iniciar ? PREPARA : INICIAL;
            PREPARA:  stateNext = SORTEIA;
            SORTEIA:  stateNext = ESPERA;
            ESPERA: begin
                if (terminar || fimT) stateNext = FIM;
                else if (jogadaEdge)  stateNext = REGISTRA;
                else                  stateNext = ESPERA;
            end
            REGISTRA: stateNext = COMPARA;
            COMPARA:  stateNext = acertou ? ACERTO : ERRO;
            ACERTO:   stateNext = SORTEIA;
            ERRO:     stateNext = ESPERA;
            FIM:      stateNext = iniciar ? PREPARA : FIM;
            default:  stateNext = INICIAL;
        endcase
    end

    always_comb begin
        zeraT       = 1'b0;
        zeraR       = 1'b0;
        zeraP       = 1'b0;
        registraR   = 1'b0;
        proximoAlvo = 1'b0;
        contaT      = 1'b0;
        contaP      = 1'b0;
        decresceT   = 1'b0;
        fimJogo     = 1'b0;
        case (stateReg)
            PREPARA: begin
                zeraT = 1'b1;
                zeraR = 1'b1;
                zeraP = 1'b1;
            end
            SORTEIA:  proximoAlvo = 1'b1;
            ESPERA:   contaT      = 1'b1;
            REGISTRA: registraR   = 1'b1;
            ACERTO:   contaP      = 1'b1;
            ERRO:     decresceT   = 1'b1;
            FIM:      fimJogo     = 1'b1;
            default: ;
        endcase
    end

    // Index 0 is the hit flag, index 1 the miss flag; loading one clears the other.
    assign timerLoad  = {stateReg == ERRO, stateReg == ACERTO};
    assign timerClear = {2{stateReg == PREPARA}} | {timerLoad[0], timerLoad[1]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gHold
            cl_hold_timer #(
                .HOLD_CYCLES(HOLD_CYCLES)
            ) uHold (
                .clock(clock),
                .reset(reset),
                .load (timerLoad[gi]),
                .clear(timerClear[gi]),
                .busy (timerBusy[gi])
            );
        end
    endgenerate

    assign mostraAcerto = timerBusy[0];
    assign mostraErro   = timerBusy[1];
    assign db_estado    = stateReg;

endmodule

// File: tb/tb_chesslab_controle.sv
// Scoreboard bench for chesslab_controle: a game-rule model predicts state and outputs per cycle.
module tb_chesslab_controle;

    localparam int H = 4;

    logic clock = 1'b0;
    logic reset, iniciar, temJogada, acertou, fimT, terminar;
    logic zeraT, zeraR, zeraP, registraR, proximoAlvo, contaT, contaP, decresceT;
    logic fimJogo, mostraAcerto, mostraErro;
    logic [3:0] db_estado;

    typedef struct packed {
        logic [3:0]  st;
        logic [10:0] outs;
    } expT;

    expT expQ[$];
    int checks = 0;
    int errors = 0;

    // Reference model: game phase, previous sensor level, remaining hit/miss display time.
    int  mState = 0;
    bit  mPrevJog = 0;
    int  mHit = 0;
    int  mMiss = 0;

    always #5 clock = ~clock;

    chesslab_controle #(.HOLD_CYCLES(H)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .temJogada(temJogada),
        .acertou(acertou), .fimT(fimT), .terminar(terminar),
        .zeraT(zeraT), .zeraR(zeraR), .zeraP(zeraP), .registraR(registraR),
        .proximoAlvo(proximoAlvo), .contaT(contaT), .contaP(contaP),
        .decresceT(decresceT), .fimJogo(fimJogo), .mostraAcerto(mostraAcerto),
        .mostraErro(mostraErro), .db_estado(db_estado)
    );

    function automatic logic [10:0] dutOuts();
        return {zeraT, zeraR, zeraP, registraR, proximoAlvo, contaT, contaP,
                decresceT, fimJogo, mostraAcerto, mostraErro};
    endfunction

    function automatic logic [10:0] expectedOuts(int s, int hit, int miss);
        logic [10:0] o;
        o = '0;
        o[10] = (s == 1);
        o[9]  = (s == 1);
        o[8]  = (s == 1);
        o[7]  = (s == 4);
        o[6]  = (s == 2);
        o[5]  = (s == 3);
        o[4]  = (s == 6);
        o[3]  = (s == 7);
        o[2]  = (s == 8);
        o[1]  = (hit != 0);
        o[0]  = (miss != 0);
        return o;
    endfunction

    // Drive one cycle of inputs and push what the DUT must show after the next rising edge.
    task automatic step(input logic r, input logic ini, input logic tj, input logic ac,
                        input logic ft, input logic te);
        bit  edgeJog;
        expT e;
        @(negedge clock);
        reset = r; iniciar = ini; temJogada = tj; acertou = ac; fimT = ft; terminar = te;
        if (r) begin
            mState = 0; mPrevJog = 0; mHit = 0; mMiss = 0;
        end else begin
            if (mState == 6)      begin mHit = H; mMiss = 0; end
            else if (mState == 7) begin mMiss = H; mHit = 0; end
            else if (mState == 1) begin mHit = 0; mMiss = 0; end
            else begin
                if (mHit > 0)  mHit--;
                if (mMiss > 0) mMiss--;
            end
            edgeJog  = tj && !mPrevJog;
            mPrevJog = tj;
            case (mState)
                0: mState = ini ? 1 : 0;
                1: mState = 2;
                2: mState = 3;
                3: mState = (te || ft) ? 8 : (edgeJog ? 4 : 3);
                4: mState = 5;
                5: mState = ac ? 6 : 7;
                6: mState = 2;
                7: mState = 3;
                8: mState = ini ? 1 : 8;
                default: mState = 0;
            endcase
        end
        e.st   = 4'(mState);
        e.outs = expectedOuts(mState, mHit, mMiss);
        expQ.push_back(e);
    endtask

    initial begin : monitor
        expT e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                if (db_estado !== e.st) begin
                    errors++;
                    $display("FAIL state: got %0d expected %0d at %0t", db_estado, e.st, $time);
                end
                checks++;
                if (dutOuts() !== e.outs) begin
                    errors++;
                    $display("FAIL outputs: got %b expected %b (state %0d) at %0t",
                             dutOuts(), e.outs, e.st, $time);
                end
                $display("cycle %0t state=%0d outs=%b", $time, db_estado, dutOuts());
            end
        end
    end

    initial begin : stimulus
        logic tj;
        reset = 1'b1; iniciar = 0; temJogada = 0; acertou = 0; fimT = 0; terminar = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // Start: 0 -> 1 -> 2 -> 3
        step(0, 1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        // Held move, hit
        repeat (10) step(0, 0, 1, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        // Miss
        repeat (6) step(0, 0, 1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0, 0);
        // Hit followed shortly by a miss
        repeat (5) step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        repeat (8) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // terminar, fimT and a move edge together in ESPERA
        step(0, 0, 1, 1, 1, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        // Restart, then reset while in COMPARA
        step(0, 1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (db_estado !== 4'd0 || dutOuts() !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got state %0d outs %b expected 0 and 0", db_estado, dutOuts());
        end
        $display("async reset in COMPARA: state=%0d outs=%b", db_estado, dutOuts());
        step(1, 0, 1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        // Randomized play
        tj = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) tj = ~tj;
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), tj,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 49) == 0));
        end
        step(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #2;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
